piso_serial_tx: RTL and testbench

- Parallel-in, serial-out framed transmitter built from clocked storage.
- Captures a DATA_WIDTH word on a valid/ready handshake.
- Shifts the word out LSB-first between a start bit (0) and a stop bit (1), holding each bit for BIT_CYCLES clocks.
- Is the transmit end of the team's serial link; a matching SIPO receiver samples serial_out.

---
 rtl/piso_pkg.sv | 22 ++
 rtl/piso_serial_tx_bit_timer.sv | 32 +++
 rtl/piso_serial_tx.sv | 111 +++++++++++
 tb/tb_piso_serial_tx.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/piso_pkg.sv
// Shared definitions for the framed serial link (transmitter and receiver).
package piso_pkg;

  // Frame sequencing states, 2-bit encoded so both ends agree on the values.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } piso_state_e;

  // Line levels on the serial wire.
  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/piso_serial_tx_bit_timer.sv
// Per-bit cycle counter: counts 0..BIT_CYCLES-1 while run is high and
// flags the last cycle of each bit. Restarts from 0 whenever run drops.
module bit_timer
  import piso_pkg::*;
#(
  parameter int unsigned BIT_CYCLES = 4
) (
  input  logic clock,
  input  logic clear,
  input  logic run,
  output logic bit_end
);

  localparam int unsigned CW = cnt_width(BIT_CYCLES);
  localparam logic [CW-1:0] TERM = CW'(BIT_CYCLES - 1);

  logic [CW-1:0] cnt_q;

  // Cycle counter, wraps at the terminal value so it never exceeds it.
  always_ff @(posedge clock) begin
    if (clear || !run) begin
      cnt_q <= '0;
    end else if (cnt_q == TERM) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign bit_end = run && (cnt_q == TERM);

endmodule

// File: rtl/piso_serial_tx.sv
// Framed parallel-in/serial-out transmitter: start bit, LSB-first payload,
// stop bit, each bit held for BIT_CYCLES clocks.
//
// state | meaning
// IDLE  | line high, ready for a word
// START | driving the start bit (0)
// DATA  | driving payload bit idx_q from shreg_q[0]
// STOP  | driving the stop bit (1); done pulses as it ends
module piso_serial_tx
  import piso_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned BIT_CYCLES = 4
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic [DATA_WIDTH-1:0] d_in,
  input  logic                  load_valid,
  output logic                  load_ready,
  output logic                  serial_out,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned IW = cnt_width(DATA_WIDTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_WIDTH - 1);

  piso_state_e           state_q;
  logic [DATA_WIDTH-1:0] shreg_q;
  logic [DATA_WIDTH-1:0] shreg_shifted;
  logic [IW-1:0]         idx_q;
  logic                  ready_q;
  logic                  line_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  bit_end;

  assign shreg_shifted = shreg_q >> 1;

  // The timer runs for the whole frame; busy_q is high exactly then.
  bit_timer #(
    .BIT_CYCLES(BIT_CYCLES)
  ) u_bit_timer (
    .clock  (clock),
    .clear  (clear),
    .run    (busy_q),
    .bit_end(bit_end)
  );

  // Frame sequencer with registered line and handshake outputs.
  always_ff @(posedge clock) begin
    if (clear) begin
      state_q <= IDLE;
      shreg_q <= '0;
      idx_q   <= '0;
      line_q  <= LINE_IDLE;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (load_valid && ready_q) begin
            shreg_q <= d_in;
            idx_q   <= '0;
            state_q <= START;
            line_q  <= START_BIT;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        START: begin
          if (bit_end) begin
            state_q <= DATA;
            line_q  <= shreg_q[0];
            idx_q   <= '0;
          end
        end
        DATA: begin
          if (bit_end) begin
            if (idx_q < LAST_IDX) begin
              shreg_q <= shreg_shifted;
              line_q  <= shreg_shifted[0];
              idx_q   <= idx_q + IW'(1);
            end else begin
              state_q <= STOP;
              line_q  <= STOP_BIT;
            end
          end
        end
        STOP: begin
          if (bit_end) begin
            state_q <= IDLE;
            line_q  <= LINE_IDLE;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign load_ready = ready_q;
  assign serial_out = line_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_piso_serial_tx.sv
// Bench for piso_serial_tx: frame-position reference model, line decoder,
// directed scenarios, random traffic, and a BIT_CYCLES=1 instance.
module tb_piso_serial_tx;

  localparam int DW    = 8;
  localparam int BC    = 4;
  localparam int FRAME = (DW + 2) * BC;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic          clear = 1'b1;
  logic          load_valid = 1'b0;
  logic [DW-1:0] d_in = '0;
  logic          load_ready, serial_out, busy, done;

  logic       clear2 = 1'b1;
  logic       lv2 = 1'b0;
  logic [3:0] d2 = '0;
  logic       lr2, so2, busy2, done2;

  piso_serial_tx #(.DATA_WIDTH(DW), .BIT_CYCLES(BC)) dut (
    .clock     (clock),
    .clear     (clear),
    .d_in      (d_in),
    .load_valid(load_valid),
    .load_ready(load_ready),
    .serial_out(serial_out),
    .busy      (busy),
    .done      (done)
  );

  piso_serial_tx #(.DATA_WIDTH(4), .BIT_CYCLES(1)) dut_b1 (
    .clock     (clock),
    .clear     (clear2),
    .d_in      (d2),
    .load_valid(lv2),
    .load_ready(lr2),
    .serial_out(so2),
    .busy      (busy2),
    .done      (done2)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: observed %0h expected %0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: a frame is just a position counter over the accepted word.
  bit            started = 1'b0;
  bit            m_active = 1'b0;
  int            m_pos = 0;
  logic [DW-1:0] m_word = '0;
  bit            m_done = 1'b0;
  logic [DW-1:0] exp_q[$];
  int            cyc = 0;
  int            done_cnt = 0;

  bit            dec_active = 1'b0;
  int            dec_cnt = 0;
  int            dec_idx = 0;
  logic [DW-1:0] dec_word = '0;

  function automatic logic frame_bit(input logic [DW-1:0] w, input int b);
    if (b == 0) return 1'b0;
    if (b <= DW) return w[b-1];
    return 1'b1;
  endfunction

  // Advance the model on each edge, then compare the DUT and decode the line.
  always @(posedge clock) begin
    cyc++;
    if (clear) begin
      m_active   = 1'b0;
      m_done     = 1'b0;
      dec_active = 1'b0;
      exp_q.delete();
    end else begin
      m_done = 1'b0;
      if (m_active) begin
        m_pos++;
        if (m_pos == FRAME) begin
          m_active = 1'b0;
          m_done   = 1'b1;
        end
      end else if (load_valid) begin
        m_active = 1'b1;
        m_pos    = 0;
        m_word   = d_in;
        exp_q.push_back(d_in);
      end
    end
    #1;
    if (started) begin
      check_val("line", serial_out, m_active ? frame_bit(m_word, m_pos / BC) : 1'b1);
      check_val("busy", busy, m_active);
      check_val("ready", load_ready, !m_active);
      check_val("done", done, m_done);
      if (done === 1'b1) done_cnt++;
      if (!dec_active) begin
        if (serial_out === 1'b0) begin
          dec_active = 1'b1;
          dec_cnt    = 0;
        end
      end else begin
        dec_cnt++;
        if (dec_cnt >= BC + BC / 2 && ((dec_cnt - BC - BC / 2) % BC) == 0) begin
          dec_idx = (dec_cnt - BC - BC / 2) / BC;
          if (dec_idx < DW) begin
            dec_word[dec_idx] = serial_out;
          end else begin
            check_val("stop_bit", serial_out, 1'b1);
            check_val("dec_pending", exp_q.size() > 0, 1'b1);
            if (exp_q.size() > 0) check_val("dec_word", dec_word, exp_q.pop_front());
            dec_active = 1'b0;
          end
        end
      end
    end
  end

  task automatic send_word(input logic [DW-1:0] w, output int acc);
    @(negedge clock);
    d_in = w;
    load_valid = 1'b1;
    @(negedge clock);
    load_valid = 1'b0;
    acc = cyc;
  endtask

  task automatic wait_done(input int lim, output int at);
    int n;
    n  = 0;
    at = -1;
    do begin
      @(negedge clock);
      n++;
    end while (done !== 1'b1 && n < lim);
    check_val("done_seen", done, 1'b1);
    at = cyc;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1);
  end

  initial begin
    int acc, dc, dc1, n0;
    logic [5:0] pat_b1;

    @(negedge clock);
    started = 1'b1;
    @(negedge clock);
    clear  = 1'b0;
    clear2 = 1'b0;
    repeat (5) @(negedge clock);
    check_val("rst_line", serial_out, 1'b1);
    check_val("rst_ready", load_ready, 1'b1);
    check_val("rst_busy", busy, 1'b0);
    check_val("rst_done", done, 1'b0);
    check_val("b1_rst_line", so2, 1'b1);
    check_val("b1_rst_ready", lr2, 1'b1);

    // single frame
    send_word(8'hA5, acc);
    wait_done(FRAME + 20, dc);
    check_val("a5_latency", dc - acc, FRAME);

    // back-to-back with load_valid held
    @(negedge clock);
    d_in = 8'h3C;
    load_valid = 1'b1;
    @(negedge clock);
    acc = cyc;
    d_in = 8'hC3;
    wait_done(FRAME + 20, dc1);
    check_val("b2b_lat1", dc1 - acc, FRAME);
    check_val("b2b_ready", load_ready, 1'b1);
    check_val("b2b_idle_line", serial_out, 1'b1);
    @(negedge clock);
    check_val("b2b_accept", busy, 1'b1);
    load_valid = 1'b0;
    wait_done(FRAME + 20, dc);
    check_val("b2b_lat2", dc - (dc1 + 1), FRAME);

    // load_valid while busy is ignored
    n0 = done_cnt;
    send_word(8'h00, acc);
    repeat (12) @(negedge clock);
    d_in = 8'hFF;
    load_valid = 1'b1;
    @(negedge clock);
    load_valid = 1'b0;
    wait_done(FRAME + 20, dc);
    check_val("ign_latency", dc - acc, FRAME);
    repeat (3) @(negedge clock);
    check_val("ign_one_done", done_cnt - n0, 1);

    // abort during data bit 3
    n0 = done_cnt;
    send_word(8'h81, acc);
    repeat (17) @(negedge clock);
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    check_val("abort_line", serial_out, 1'b1);
    check_val("abort_ready", load_ready, 1'b1);
    check_val("abort_busy", busy, 1'b0);
    repeat (FRAME + 10) @(negedge clock);
    check_val("abort_no_done", done_cnt - n0, 0);
    send_word(8'h55, acc);
    wait_done(FRAME + 20, dc);
    check_val("after_abort_lat", dc - acc, FRAME);

    // random traffic, occasional clear
    for (int i = 0; i < 600; i++) begin
      @(negedge clock);
      load_valid = ($urandom_range(0, 3) == 0);
      d_in = DW'($urandom);
      clear = ($urandom_range(0, 199) == 0);
    end
    @(negedge clock);
    clear = 1'b0;
    load_valid = 1'b0;
    repeat (FRAME + 5) @(negedge clock);

    // BIT_CYCLES=1, DATA_WIDTH=4, word 1001: line 0,1,0,0,1,1 then done
    pat_b1 = 6'b110010;
    @(negedge clock);
    d2  = 4'b1001;
    lv2 = 1'b1;
    @(posedge clock);
    #1;
    lv2 = 1'b0;
    d2  = 4'b0110;
    check_val("b1_line0", so2, pat_b1[0]);
    check_val("b1_busy", busy2, 1'b1);
    for (int j = 1; j < 6; j++) begin
      @(posedge clock);
      #1;
      check_val("b1_line", so2, pat_b1[j]);
      check_val("b1_no_done", done2, 1'b0);
    end
    @(posedge clock);
    #1;
    check_val("b1_done", done2, 1'b1);
    check_val("b1_idle_busy", busy2, 1'b0);
    check_val("b1_idle_ready", lr2, 1'b1);
    check_val("b1_idle_line", so2, 1'b1);
    @(posedge clock);
    #1;
    check_val("b1_done_pulse", done2, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
